// File: rtl/bitwise_op_csr.sv
// Register-mapped two-operand bitwise engine: FIFOs A/B feed op(A,B) into FIFO Y.
// Optional sticky error flags at read address 5 via BITWISE_OP_ERR_FLAGS_EN.
module bitwise_op_csr #(
  parameter int WIDTH     = 8,
  parameter int IN_DEPTH  = 2,
  parameter int OUT_DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [2:0]       write_address,
  input  logic [WIDTH-1:0] write_data,
  input  logic             write_en,
  output logic             write_rdy,
  input  logic [2:0]       read_address,
  input  logic             read_en,
  output logic [WIDTH-1:0] read_data,
  output logic             read_rdy
);

  localparam int IAW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int OAW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int ICW = $clog2(IN_DEPTH + 1);
  localparam int OCW = $clog2(OUT_DEPTH + 1);

  logic [WIDTH-1:0] mem_a_q [IN_DEPTH];
  logic [WIDTH-1:0] mem_a_d [IN_DEPTH];
  logic [WIDTH-1:0] mem_b_q [IN_DEPTH];
  logic [WIDTH-1:0] mem_b_d [IN_DEPTH];
  logic [WIDTH-1:0] mem_y_q [OUT_DEPTH];
  logic [WIDTH-1:0] mem_y_d [OUT_DEPTH];

  logic [IAW-1:0] wp_a_q, wp_a_d, rp_a_q, rp_a_d;
  logic [IAW-1:0] wp_b_q, wp_b_d, rp_b_q, rp_b_d;
  logic [OAW-1:0] wp_y_q, wp_y_d, rp_y_q, rp_y_d;
  logic [ICW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [OCW-1:0] cnt_y_q, cnt_y_d;

  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rdy_q;

  logic full_a, full_b, full_y;
  logic empty_a, empty_b, empty_y;
  logic wr_a, wr_b, push_a, push_b;
  logic rd_y, pop_y, fire;
  logic [WIDTH-1:0] head_a, head_b, head_y, res;
  logic [WIDTH-1:0] flag_rd;

  function automatic logic [IAW-1:0] inc_i(input logic [IAW-1:0] p);
    return (p == IAW'(IN_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [OAW-1:0] inc_o(input logic [OAW-1:0] p);
    return (p == OAW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_a  = (cnt_a_q == ICW'(IN_DEPTH));
  assign full_b  = (cnt_b_q == ICW'(IN_DEPTH));
  assign full_y  = (cnt_y_q == OCW'(OUT_DEPTH));
  assign empty_a = (cnt_a_q == '0);
  assign empty_b = (cnt_b_q == '0);
  assign empty_y = (cnt_y_q == '0);

  assign wr_a   = write_en && (write_address == 3'd4);
  assign wr_b   = write_en && (write_address == 3'd5);
  assign push_a = wr_a && !full_a;
  assign push_b = wr_b && !full_b;
  assign rd_y   = read_en && (read_address == 3'd3);
  assign pop_y  = rd_y && !empty_y;
  // Start-of-cycle full check: a same-cycle pop of Y never frees room
  assign fire   = !empty_a && !empty_b && !full_y;

  assign head_a = mem_a_q[rp_a_q];
  assign head_b = mem_b_q[rp_b_q];
  assign head_y = mem_y_q[rp_y_q];

  always_comb begin
    res = '0;
    unique case (mode_q)
      2'd0: res = head_a | head_b;
      2'd1: res = head_a & head_b;
      2'd2: res = head_a ^ head_b;
      2'd3: res = ~(head_a & head_b);
    endcase
  end

  always_comb begin
    mem_a_d = mem_a_q;
    mem_b_d = mem_b_q;
    mem_y_d = mem_y_q;
    wp_a_d  = wp_a_q;
    rp_a_d  = rp_a_q;
    wp_b_d  = wp_b_q;
    rp_b_d  = rp_b_q;
    wp_y_d  = wp_y_q;
    rp_y_d  = rp_y_q;
    mode_d  = mode_q;
    if (push_a) begin
      mem_a_d[wp_a_q] = write_data;
      wp_a_d = inc_i(wp_a_q);
    end
    if (push_b) begin
      mem_b_d[wp_b_q] = write_data;
      wp_b_d = inc_i(wp_b_q);
    end
    if (fire) begin
      rp_a_d = inc_i(rp_a_q);
      rp_b_d = inc_i(rp_b_q);
      mem_y_d[wp_y_q] = res;
      wp_y_d = inc_o(wp_y_q);
    end
    if (pop_y) rp_y_d = inc_o(rp_y_q);
    if (write_en && write_address == 3'd6) mode_d = write_data[1:0];
    cnt_a_d = cnt_a_q + ICW'(push_a) - ICW'(fire);
    cnt_b_d = cnt_b_q + ICW'(push_b) - ICW'(fire);
    cnt_y_d = cnt_y_q + OCW'(fire) - OCW'(pop_y);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (read_en) begin
      case (read_address)
        3'd0:    rdata_d = WIDTH'(!full_a);
        3'd1:    rdata_d = WIDTH'(!full_b);
        3'd2:    rdata_d = WIDTH'(!empty_y);
        3'd3:    rdata_d = empty_y ? '0 : head_y;
        3'd4:    rdata_d = WIDTH'(mode_q);
        3'd5:    rdata_d = flag_rd;
        default: rdata_d = '0;
      endcase
    end
  end

`ifdef BITWISE_OP_ERR_FLAGS_EN
  logic [2:0] flags_q, flags_d;

  // Clear-on-read first, so a same-cycle set event survives
  always_comb begin
    flags_d = flags_q;
    if (read_en && read_address == 3'd5) flags_d = '0;
    flags_d = flags_d | {rd_y && empty_y, wr_b && full_b, wr_a && full_a};
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  assign flag_rd = WIDTH'(flags_q);
`else
  assign flag_rd = '0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      mem_a_q <= '{default: '0};
      mem_b_q <= '{default: '0};
      mem_y_q <= '{default: '0};
      wp_a_q  <= '0;
      rp_a_q  <= '0;
      wp_b_q  <= '0;
      rp_b_q  <= '0;
      wp_y_q  <= '0;
      rp_y_q  <= '0;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      cnt_y_q <= '0;
      mode_q  <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      mem_a_q <= mem_a_d;
      mem_b_q <= mem_b_d;
      mem_y_q <= mem_y_d;
      wp_a_q  <= wp_a_d;
      rp_a_q  <= rp_a_d;
      wp_b_q  <= wp_b_d;
      rp_b_q  <= rp_b_d;
      wp_y_q  <= wp_y_d;
      rp_y_q  <= rp_y_d;
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;
      cnt_y_q <= cnt_y_d;
      mode_q  <= mode_d;
      rdata_q <= rdata_d;
      rdy_q   <= 1'b1;
    end
  end

  assign read_data = rdata_q;
  assign write_rdy = rdy_q;
  assign read_rdy  = rdy_q;

endmodule

// File: tb/tb_bitwise_op_csr.sv
// Directed bench for bitwise_op_csr (WIDTH=8, depths 2).
// Flag expectations follow BITWISE_OP_ERR_FLAGS_EN.
module tb_bitwise_op_csr;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [2:0] write_address;
  logic [7:0] write_data;
  logic       write_en;
  logic       write_rdy;
  logic [2:0] read_address;
  logic       read_en;
  logic [7:0] read_data;
  logic       read_rdy;

  int tests = 0;
  int fails = 0;

  bitwise_op_csr #(.WIDTH(8), .IN_DEPTH(2), .OUT_DEPTH(2)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .write_address(write_address),
    .write_data   (write_data),
    .write_en     (write_en),
    .write_rdy    (write_rdy),
    .read_address (read_address),
    .read_en      (read_en),
    .read_data    (read_data),
    .read_rdy     (read_rdy)
  );

  always #5 CLK = ~CLK;

`ifdef BITWISE_OP_ERR_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    write_address = a;
    write_data    = d;
    write_en      = 1'b1;
    tick();
    write_en      = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a);
    read_address = a;
    read_en      = 1'b1;
    tick();
    read_en      = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (read_data !== 8'h00 || write_rdy !== 1'b0 || read_rdy !== 1'b0) begin
        fails++;
        $display("FAIL reset_hold got data=%h wr=%b rd=%b want 00/0/0",
                 read_data, write_rdy, read_rdy);
      end
    end
    RST_N = 1'b1;
    tick();
    tests++;
    if (write_rdy !== 1'b1 || read_rdy !== 1'b1) begin
      fails++;
      $display("FAIL reset_rdy got wr=%b rd=%b want 1/1", write_rdy, read_rdy);
    end
    rd(3'd0);
    tests++;
    if (read_data !== 8'h01) begin
      fails++;
      $display("FAIL reset_a_nf got %h want 01", read_data);
    end
    rd(3'd1);
    tests++;
    if (read_data !== 8'h01) begin
      fails++;
      $display("FAIL reset_b_nf got %h want 01", read_data);
    end
    rd(3'd2);
    tests++;
    if (read_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_y_ne got %h want 00", read_data);
    end
  endtask

  task automatic test_underflow();
    logic [7:0] exp_f;
    exp_f = FLAGS ? 8'h04 : 8'h00;
    rd(3'd3);
    tests++;
    if (read_data !== 8'h00) begin
      fails++;
      $display("FAIL uf_read got %h want 00", read_data);
    end
    rd(3'd5);
    tests++;
    if (read_data !== exp_f) begin
      fails++;
      $display("FAIL uf_flags got %h want %h", read_data, exp_f);
    end
    rd(3'd5);
    tests++;
    if (read_data !== 8'h00) begin
      fails++;
      $display("FAIL uf_clear got %h want 00", read_data);
    end
  endtask

  task automatic test_op(input logic [1:0] m, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp);
    wr(3'd6, {6'd0, m});
    wr(3'd4, a);
    wr(3'd5, b);
    tick();
    rd(3'd3);
    tests++;
    if (read_data !== exp) begin
      fails++;
      $display("FAIL op_m%0d a=%h b=%h got %h want %h", m, a, b, read_data, exp);
    end
  endtask

  task automatic test_mode_concurrency();
    wr(3'd6, 8'd1);
    wr(3'd4, 8'hAA);
    wr(3'd5, 8'hCC);
    wr(3'd6, 8'd2);
    rd(3'd3);
    tests++;
    if (read_data !== 8'h88) begin
      fails++;
      $display("FAIL mode_race got %h want 88", read_data);
    end
    rd(3'd4);
    tests++;
    if (read_data !== 8'h02) begin
      fails++;
      $display("FAIL mode_read got %h want 02", read_data);
    end
    wr(3'd4, 8'hAA);
    wr(3'd5, 8'hCC);
    tick();
    rd(3'd3);
    tests++;
    if (read_data !== 8'h66) begin
      fails++;
      $display("FAIL mode_new got %h want 66", read_data);
    end
    tick();
    tick();
    tests++;
    if (read_data !== 8'h66) begin
      fails++;
      $display("FAIL rd_hold got %h want 66", read_data);
    end
    rd(3'd7);
    tests++;
    if (read_data !== 8'h00) begin
      fails++;
      $display("FAIL rd_unmapped got %h want 00", read_data);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp_y [4];
    logic [7:0] exp_f;
    exp_y = '{8'h22, 8'h33, 8'h44, 8'h00};
    wr(3'd6, 8'd0);
    for (int i = 1; i <= 5; i++) begin
      wr(3'd4, 8'(i));
      wr(3'd5, 8'(i << 4));
    end
    exp_f = FLAGS ? 8'h03 : 8'h00;
    rd(3'd5);
    tests++;
    if (read_data !== exp_f) begin
      fails++;
      $display("FAIL bp_flags got %h want %h", read_data, exp_f);
    end
    rd(3'd0);
    tests++;
    if (read_data !== 8'h00) begin
      fails++;
      $display("FAIL bp_a_full got %h want 00", read_data);
    end
    rd(3'd2);
    tests++;
    if (read_data !== 8'h01) begin
      fails++;
      $display("FAIL bp_y_ne got %h want 01", read_data);
    end
    rd(3'd3);
    tests++;
    if (read_data !== 8'h11) begin
      fails++;
      $display("FAIL bp_y0 got %h want 11", read_data);
    end
    // Pop of a full Y must not have let compute drain A that edge
    rd(3'd0);
    tests++;
    if (read_data !== 8'h00) begin
      fails++;
      $display("FAIL bp_no_push got %h want 00", read_data);
    end
    rd(3'd0);
    tests++;
    if (read_data !== 8'h01) begin
      fails++;
      $display("FAIL bp_push_next got %h want 01", read_data);
    end
    for (int i = 0; i < 4; i++) begin
      rd(3'd3);
      tests++;
      if (read_data !== exp_y[i]) begin
        fails++;
        $display("FAIL bp_drain%0d got %h want %h", i, read_data, exp_y[i]);
      end
    end
    exp_f = FLAGS ? 8'h04 : 8'h00;
    rd(3'd5);
    tests++;
    if (read_data !== exp_f) begin
      fails++;
      $display("FAIL bp_uf_flag got %h want %h", read_data, exp_f);
    end
    wr(3'd4, 8'h05);
    wr(3'd5, 8'h0A);
    tick();
    rd(3'd3);
    tests++;
    if (read_data !== 8'h0F) begin
      fails++;
      $display("FAIL bp_resume got %h want 0f", read_data);
    end
  endtask

  task automatic test_mid_reset();
    wr(3'd6, 8'd3);
    wr(3'd4, 8'h01);
    wr(3'd4, 8'h02);
    wr(3'd5, 8'h03);
    tick();
    rd(3'd4);
    tests++;
    if (read_data !== 8'h03) begin
      fails++;
      $display("FAIL mr_pre_mode got %h want 03", read_data);
    end
    RST_N = 1'b0;
    tick();
    tests++;
    if (read_data !== 8'h00 || write_rdy !== 1'b0 || read_rdy !== 1'b0) begin
      fails++;
      $display("FAIL mr_in_reset got data=%h wr=%b rd=%b want 00/0/0",
               read_data, write_rdy, read_rdy);
    end
    RST_N = 1'b1;
    tick();
    tests++;
    if (write_rdy !== 1'b1 || read_rdy !== 1'b1) begin
      fails++;
      $display("FAIL mr_rdy got wr=%b rd=%b want 1/1", write_rdy, read_rdy);
    end
    rd(3'd0);
    tests++;
    if (read_data !== 8'h01) begin
      fails++;
      $display("FAIL mr_a_nf got %h want 01", read_data);
    end
    rd(3'd1);
    tests++;
    if (read_data !== 8'h01) begin
      fails++;
      $display("FAIL mr_b_nf got %h want 01", read_data);
    end
    rd(3'd2);
    tests++;
    if (read_data !== 8'h00) begin
      fails++;
      $display("FAIL mr_y_ne got %h want 00", read_data);
    end
    rd(3'd4);
    tests++;
    if (read_data !== 8'h00) begin
      fails++;
      $display("FAIL mr_mode got %h want 00", read_data);
    end
    rd(3'd3);
    tests++;
    if (read_data !== 8'h00) begin
      fails++;
      $display("FAIL mr_y_pop got %h want 00", read_data);
    end
  endtask

  initial begin
    RST_N         = 1'b0;
    write_address = '0;
    write_data    = '0;
    write_en      = 1'b0;
    read_address  = '0;
    read_en       = 1'b0;
    test_reset();
    test_underflow();
    test_op(2'd0, 8'h0F, 8'hF0, 8'hFF);
    test_op(2'd1, 8'h0F, 8'hF0, 8'h00);
    test_op(2'd2, 8'h0F, 8'hF0, 8'hFF);
    test_op(2'd3, 8'h0F, 8'hF0, 8'hFF);
    test_op(2'd0, 8'hAA, 8'hCC, 8'hEE);
    test_op(2'd1, 8'hAA, 8'hCC, 8'h88);
    test_op(2'd2, 8'hAA, 8'hCC, 8'h66);
    test_op(2'd3, 8'hAA, 8'hCC, 8'h77);
    test_mode_concurrency();
    test_backpressure();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
